pulse_rate_meter: RTL and testbench

PULSE_RATE_METER -- requirements
Module: pulse_rate_meter

---
 rtl/pulse_rate_pkg.sv | 15 +
 rtl/pulse_rate_meter_if.sv | 12 +
 rtl/pulse_rate_channel.sv | 73 +++++++
 rtl/pulse_rate_meter.sv | 109 ++++++++++
 tb/tb_pulse_rate_meter.sv | 353 +++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/pulse_rate_pkg.sv
// Shared defaults and helpers for the pulse rate meter.
// Both the top and the per-channel block import this package.
package pulse_rate_pkg;

    localparam int DEF_N_CH            = 2;
    localparam int DEF_CNT_W           = 8;
    localparam int DEF_WINDOW_CYCLES   = 50_000_000;
    localparam int DEF_DEBOUNCE_CYCLES = 4;

    // Width of the window counter that runs 0..cycles-1.
    function automatic int win_cnt_w(input int cycles);
        return (cycles < 2) ? 1 : $clog2(cycles);
    endfunction

endpackage

// File: rtl/pulse_rate_meter_if.sv
// Per-channel link between the window timer (slave side) and one channel (master side).
// The link has no handshake. The top drives clear, and the channel answers with its count projected to this cycle.
interface pulse_rate_meter_if #(
    parameter int CNT_W = 8
);
    logic             clear;
    logic [CNT_W-1:0] count_next;
    logic             sat_next;

    modport master (input clear, output count_next, sat_next);
    modport slave  (output clear, input count_next, sat_next);
endinterface

// File: rtl/pulse_rate_channel.sv
// One pulse channel: 2-flop synchronizer, run-length debouncer, rising-edge detect,
// and a saturating event counter with a sticky saturation flag.
module pulse_rate_channel
    import pulse_rate_pkg::*;
#(
    parameter int CNT_W           = DEF_CNT_W,
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              pulse_in,
    pulse_rate_meter_if.master bus
);
    localparam int               DB_W    = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [DB_W-1:0]  DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic             sync1_q, sync1_d;
    logic             sync2_q, sync2_d;
    logic             level_q, level_d;
    logic [DB_W-1:0]  db_cnt_q, db_cnt_d;
    logic [CNT_W-1:0] count_q, count_d, count_next;
    logic             sat_q, sat_d, sat_next;
    logic             rise;

    always_comb begin
        sync1_d  = pulse_in;
        sync2_d  = sync1_q;
        level_d  = level_q;
        db_cnt_d = '0;
        rise     = 1'b0;
        // A sample that matches the accepted level leaves db_cnt_d at zero, restarting the run.
        if (sync2_q != level_q) begin
            if (db_cnt_q == DB_LAST) begin
                level_d = sync2_q;
                rise    = sync2_q;
            end else begin
                db_cnt_d = db_cnt_q + 1'b1;
            end
        end

        count_next = count_q;
        sat_next   = sat_q;
        if (rise) begin
            if (count_q == CNT_MAX) sat_next   = 1'b1;
            else                    count_next = count_q + 1'b1;
        end
        count_d = bus.clear ? '0   : count_next;
        sat_d   = bus.clear ? 1'b0 : sat_next;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1_q  <= 1'b0;
            sync2_q  <= 1'b0;
            level_q  <= 1'b0;
            db_cnt_q <= '0;
            count_q  <= '0;
            sat_q    <= 1'b0;
        end else begin
            sync1_q  <= sync1_d;
            sync2_q  <= sync2_d;
            level_q  <= level_d;
            db_cnt_q <= db_cnt_d;
            count_q  <= count_d;
            sat_q    <= sat_d;
        end
    end

    assign bus.count_next = count_next;
    assign bus.sat_next   = sat_next;

endmodule

// File: rtl/pulse_rate_meter.sv
// Multi-channel pulse rate meter. It counts debounced rising edges per fixed window
// and publishes the counts with a saturation flag and threshold alarms.
module pulse_rate_meter
    import pulse_rate_pkg::*;
#(
    parameter int N_CH            = DEF_N_CH,
    parameter int CNT_W           = DEF_CNT_W,
    parameter int WINDOW_CYCLES   = DEF_WINDOW_CYCLES,
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    enable,
    input  logic [N_CH-1:0]         pulse_in,
    input  logic [CNT_W-1:0]        hi_thresh,
    input  logic [CNT_W-1:0]        lo_thresh,
    output logic [N_CH*CNT_W-1:0]   rate,
    output logic                    rate_valid,
    output logic [N_CH-1:0]         rate_sat,
    output logic [N_CH-1:0]         hi_alarm,
    output logic [N_CH-1:0]         lo_alarm
);
    localparam int              WIN_W    = win_cnt_w(WINDOW_CYCLES);
    localparam logic [WIN_W-1:0] WIN_LAST = WIN_W'(WINDOW_CYCLES - 1);

    logic [WIN_W-1:0]      win_q, win_d;
    logic                  terminal;
    logic [N_CH*CNT_W-1:0] count_next_all;
    logic [N_CH-1:0]       sat_next_all;

    logic [N_CH*CNT_W-1:0] rate_q, rate_d;
    logic                  rate_valid_q, rate_valid_d;
    logic [N_CH-1:0]       rate_sat_q, rate_sat_d;
    logic [N_CH-1:0]       hi_alarm_q, hi_alarm_d;
    logic [N_CH-1:0]       lo_alarm_q, lo_alarm_d;

    assign terminal = enable && (win_q == WIN_LAST);

    pulse_rate_meter_if #(.CNT_W(CNT_W)) ch_if [N_CH] ();

    genvar gi;
    generate
        for (gi = 0; gi < N_CH; gi++) begin : g_ch
            // The projected count already holds a terminal-cycle edge, so the clear cannot lose or double it.
            assign ch_if[gi].clear                        = ~enable | terminal;
            assign count_next_all[gi*CNT_W +: CNT_W]      = ch_if[gi].count_next;
            assign sat_next_all[gi]                       = ch_if[gi].sat_next;

            pulse_rate_channel #(
                .CNT_W           (CNT_W),
                .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
            ) u_ch (
                .clk      (clk),
                .reset    (reset),
                .pulse_in (pulse_in[gi]),
                .bus      (ch_if[gi].master)
            );
        end
    endgenerate

    // rate_valid is a one-cycle strobe without backpressure. rate, rate_sat and the alarms hold between strobes.
    always_comb begin
        win_d        = win_q;
        rate_d       = rate_q;
        rate_valid_d = 1'b0;
        rate_sat_d   = rate_sat_q;
        hi_alarm_d   = hi_alarm_q;
        lo_alarm_d   = lo_alarm_q;
        if (!enable) begin
            win_d = '0;
        end else if (terminal) begin
            win_d        = '0;
            rate_d       = count_next_all;
            rate_sat_d   = sat_next_all;
            rate_valid_d = 1'b1;
            for (int c = 0; c < N_CH; c++) begin
                hi_alarm_d[c] = count_next_all[c*CNT_W +: CNT_W] > hi_thresh;
                lo_alarm_d[c] = count_next_all[c*CNT_W +: CNT_W] < lo_thresh;
            end
        end else begin
            win_d = win_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            win_q        <= '0;
            rate_q       <= '0;
            rate_valid_q <= 1'b0;
            rate_sat_q   <= '0;
            hi_alarm_q   <= '0;
            lo_alarm_q   <= '0;
        end else begin
            win_q        <= win_d;
            rate_q       <= rate_d;
            rate_valid_q <= rate_valid_d;
            rate_sat_q   <= rate_sat_d;
            hi_alarm_q   <= hi_alarm_d;
            lo_alarm_q   <= lo_alarm_d;
        end
    end

    assign rate       = rate_q;
    assign rate_valid = rate_valid_q;
    assign rate_sat   = rate_sat_q;
    assign hi_alarm   = hi_alarm_q;
    assign lo_alarm   = lo_alarm_q;

endmodule

// File: tb/tb_pulse_rate_meter.sv
// Bench for pulse_rate_meter. Two builds share the same stimulus: one debounces over 3 samples, the other over 1.
// A window-level model queues expected results, and a monitor compares them on every rate_valid.
`timescale 1ns/1ps
module tb_pulse_rate_meter;
    localparam int N_CH  = 2;
    localparam int CNT_W = 4;
    localparam int WIN   = 100;
    localparam int NI    = 2;
    localparam int DB0   = 3;
    localparam int DB1   = 1;
    localparam int W     = N_CH*CNT_W + 3*N_CH;
    localparam int HMAX  = 4096;
    localparam int CMAX  = (1 << CNT_W) - 1;

    logic                  clk;
    logic                  reset;
    logic                  enable;
    logic                  pin0, pin1;
    logic [N_CH-1:0]       pulse_in;
    logic [CNT_W-1:0]      hi_thresh, lo_thresh;
    logic [N_CH*CNT_W-1:0] rate_o [NI];
    logic                  valid_o [NI];
    logic [N_CH-1:0]       sat_o [NI];
    logic [N_CH-1:0]       hi_o [NI];
    logic [N_CH-1:0]       lo_o [NI];

    assign pulse_in = {pin1, pin0};

    pulse_rate_meter #(.N_CH(N_CH), .CNT_W(CNT_W), .WINDOW_CYCLES(WIN), .DEBOUNCE_CYCLES(DB0)) u_dut_db3 (
        .clk(clk), .reset(reset), .enable(enable), .pulse_in(pulse_in),
        .hi_thresh(hi_thresh), .lo_thresh(lo_thresh),
        .rate(rate_o[0]), .rate_valid(valid_o[0]), .rate_sat(sat_o[0]),
        .hi_alarm(hi_o[0]), .lo_alarm(lo_o[0]));

    pulse_rate_meter #(.N_CH(N_CH), .CNT_W(CNT_W), .WINDOW_CYCLES(WIN), .DEBOUNCE_CYCLES(DB1)) u_dut_db1 (
        .clk(clk), .reset(reset), .enable(enable), .pulse_in(pulse_in),
        .hi_thresh(hi_thresh), .lo_thresh(lo_thresh),
        .rate(rate_o[1]), .rate_valid(valid_o[1]), .rate_sat(sat_o[1]),
        .hi_alarm(hi_o[1]), .lo_alarm(lo_o[1]));

    // ---------------- clock / reset ----------------
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- bookkeeping ----------------
    int n_checks = 0;
    int n_err    = 0;
    int cyc;
    int last_valid_cyc [NI];
    int valid_cnt [NI];
    logic [W-1:0] exp_q [NI][$];
    logic [W-1:0] held [NI];

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic int db_of(input int k);
        return (k == 0) ? DB0 : DB1;
    endfunction

    // ---------------- reference model ----------------
    // Works from edge indices. An accepted change is D consecutive synchronized samples,
    // and the debouncer at edge t sees raw[t-2]. A window covers WIN enabled edges counted from its start edge.
    bit raw_h [N_CH][HMAX];
    bit lvl [NI][N_CH];
    int rises [NI][N_CH];
    int ws;
    bit all_new;
    logic [N_CH*CNT_W-1:0] m_rate;
    logic [N_CH-1:0] m_sat, m_hi, m_lo;
    int m_n;

    function automatic bit raw_at(input int c, input int idx);
        if (idx < 1 || idx >= HMAX) return 1'b0;
        return raw_h[c][idx];
    endfunction

    initial begin
        cyc = 0;
        ws  = 0;
        forever begin
            @(posedge clk);
            if (reset) begin
                cyc = 0;
                ws  = 0;
                for (int k = 0; k < NI; k++)
                    for (int c = 0; c < N_CH; c++) begin
                        lvl[k][c]   = 1'b0;
                        rises[k][c] = 0;
                    end
            end else begin
                cyc++;
                if (cyc < HMAX) begin
                    raw_h[0][cyc] = pulse_in[0];
                    raw_h[1][cyc] = pulse_in[1];
                end
                for (int k = 0; k < NI; k++)
                    for (int c = 0; c < N_CH; c++) begin
                        all_new = 1'b1;
                        for (int j = 1; j <= db_of(k); j++)
                            if (raw_at(c, cyc - 1 - j) == lvl[k][c]) all_new = 1'b0;
                        if (all_new) begin
                            lvl[k][c] = ~lvl[k][c];
                            if (lvl[k][c] && enable) rises[k][c]++;
                        end
                    end
                if (!enable) begin
                    ws = 0;
                    for (int k = 0; k < NI; k++)
                        for (int c = 0; c < N_CH; c++) rises[k][c] = 0;
                end else begin
                    if (ws == 0) ws = cyc;
                    if (cyc - ws == WIN - 1) begin
                        for (int k = 0; k < NI; k++) begin
                            for (int c = 0; c < N_CH; c++) begin
                                m_n = (rises[k][c] > CMAX) ? CMAX : rises[k][c];
                                m_rate[c*CNT_W +: CNT_W] = CNT_W'(m_n);
                                m_sat[c] = rises[k][c] > CMAX;
                                m_hi[c]  = m_n > int'(hi_thresh);
                                m_lo[c]  = m_n < int'(lo_thresh);
                                rises[k][c] = 0;
                            end
                            exp_q[k].push_back({m_rate, m_sat, m_hi, m_lo});
                        end
                        ws = 0;
                    end
                end
            end
        end
    end

    // ---------------- monitor / scoreboard ----------------
    logic [W-1:0] got, e;
    initial begin
        for (int k = 0; k < NI; k++) begin
            held[k] = '0;
            last_valid_cyc[k] = -1;
            valid_cnt[k] = 0;
        end
        forever begin
            @(negedge clk);
            if (reset) begin
                for (int k = 0; k < NI; k++) begin
                    held[k] = '0;
                    exp_q[k].delete();
                end
            end else begin
                for (int k = 0; k < NI; k++) begin
                    got = {rate_o[k], sat_o[k], hi_o[k], lo_o[k]};
                    n_checks++;
                    if (valid_o[k]) begin
                        valid_cnt[k]++;
                        last_valid_cyc[k] = cyc;
                        if (exp_q[k].size() == 0) begin
                            n_err++;
                            $display("FAIL dut%0d unexpected rate_valid at cycle %0d: got %h expected none", k, cyc, got);
                        end else begin
                            e = exp_q[k].pop_front();
                            held[k] = e;
                            if (got !== e) begin
                                n_err++;
                                $display("FAIL dut%0d window result at cycle %0d: got %h expected %h", k, cyc, got, e);
                            end
                        end
                    end else if (got !== held[k]) begin
                        n_err++;
                        $display("FAIL dut%0d held outputs at cycle %0d: got %h expected %h", k, cyc, got, held[k]);
                    end
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic do_reset();
        @(negedge clk);
        reset  = 1'b1;
        enable = 1'b0;
        pin0   = 1'b0;
        pin1   = 1'b0;
        repeat (3) @(negedge clk);
        reset  = 1'b0;
        enable = 1'b1;
    endtask

    task automatic wait_cyc(input int c);
        while (cyc < c) @(negedge clk);
    endtask

    task automatic pulse(input int ch, input int hi, input int lo);
        if (ch == 0) pin0 = 1'b1; else pin1 = 1'b1;
        repeat (hi) @(negedge clk);
        if (ch == 0) pin0 = 1'b0; else pin1 = 1'b0;
        repeat (lo) @(negedge clk);
    endtask

    // ---------------- stimulus ----------------
    int snap, h, l;
    initial begin
        reset = 1'b1; enable = 1'b0; pin0 = 1'b0; pin1 = 1'b0;
        hi_thresh = 4'd10; lo_thresh = 4'd1;
        #1;
        check("reset rate",       int'(rate_o[0]), 0);
        check("reset rate_valid", int'(valid_o[0]), 0);

        // Clean pulses on ch0, silent ch1.
        do_reset();
        wait_cyc(3);
        repeat (5) pulse(0, 10, 10);
        wait_cyc(105);
        check("clean first valid cycle",  last_valid_cyc[0], WIN);
        check("clean rate ch0",           int'(rate_o[0][3:0]), 5);
        check("clean rate ch1",           int'(rate_o[0][7:4]), 0);
        check("clean lo_alarm",           int'(lo_o[0]), 2);
        check("clean hi_alarm",           int'(hi_o[0]), 0);

        // Glitches of 1 and 2 cycles, then a 4-cycle pulse.
        do_reset();
        wait_cyc(3);
        pulse(0, 1, 10);
        pulse(0, 2, 10);
        pulse(0, 4, 10);
        wait_cyc(105);
        check("glitch rate ch0 db3", int'(rate_o[0][3:0]), 1);
        check("glitch rate ch0 db1", int'(rate_o[1][3:0]), 3);

        // Saturation with fast pulses on ch1.
        do_reset();
        hi_thresh = 4'd10; lo_thresh = 4'd0;
        wait_cyc(3);
        repeat (20) pulse(1, 2, 2);
        wait_cyc(105);
        check("sat rate ch1 db1",  int'(rate_o[1][7:4]), 15);
        check("sat flag db1",      int'(sat_o[1]), 2);
        check("sat hi_alarm db1",  int'(hi_o[1]), 2);
        check("sat rate ch1 db3",  int'(rate_o[0][7:4]), 0);
        wait_cyc(205);
        check("quiet rate ch1 db1", int'(rate_o[1][7:4]), 0);
        check("quiet sat db1",      int'(sat_o[1]), 0);

        // Accepted edge landing on the terminal cycle.
        do_reset();
        wait_cyc(95);
        pin0 = 1'b1;
        wait_cyc(105);
        check("terminal edge counted", int'(rate_o[0][3:0]), 1);
        wait_cyc(115);
        pin0 = 1'b0;
        wait_cyc(205);
        check("terminal next window", int'(rate_o[0][3:0]), 0);

        // Enable dropped for 37 cycles mid-window.
        do_reset();
        hi_thresh = 4'd15; lo_thresh = 4'd0;
        wait_cyc(3);
        repeat (3) pulse(0, 10, 10);
        wait_cyc(130);
        enable = 1'b0;
        snap = valid_cnt[0];
        pulse(0, 10, 10);
        wait_cyc(167);
        enable = 1'b1;
        wait_cyc(200);
        check("disabled rate holds", int'(rate_o[0][3:0]), 3);
        wait_cyc(266);
        check("no valid after disable", valid_cnt[0] - snap, 0);
        wait_cyc(270);
        check("re-enable valid cycle", last_valid_cyc[0], 267);
        check("re-enable rate ch0",    int'(rate_o[0][3:0]), 0);

        // Reset mid-window with pending counts.
        do_reset();
        lo_thresh = 4'd3;
        wait_cyc(3);
        repeat (2) pulse(0, 10, 10);
        wait_cyc(105);
        check("pre-reset rate ch0", int'(rate_o[0][3:0]), 2);
        check("pre-reset lo_alarm", int'(lo_o[0][0]), 1);
        repeat (3) pulse(0, 10, 10);
        wait_cyc(170);
        reset = 1'b1;
        #1;
        check("mid reset rate",       int'(rate_o[0]), 0);
        check("mid reset rate_valid", int'(valid_o[0]), 0);
        check("mid reset rate_sat",   int'(sat_o[0]), 0);
        check("mid reset hi_alarm",   int'(hi_o[0]), 0);
        check("mid reset lo_alarm",   int'(lo_o[0]), 0);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        wait_cyc(105);
        check("post-reset valid cycle", last_valid_cyc[0], WIN);
        check("post-reset rate ch0",    int'(rate_o[0][3:0]), 0);

        // Randomized traffic, thresholds and enable drops.
        do_reset();
        hi_thresh = CNT_W'($urandom_range(0, CMAX));
        lo_thresh = CNT_W'($urandom_range(0, CMAX));
        fork
            begin : drv_ch0
                int left0;
                left0 = 1500;
                while (left0 > 0) begin
                    h = $urandom_range(1, 8);
                    pulse(0, h, 1);
                    left0 -= h + 1;
                end
            end
            begin : drv_ch1
                int left1, h1, l1;
                left1 = 1500;
                while (left1 > 0) begin
                    h1 = $urandom_range(1, 8);
                    l1 = $urandom_range(1, 8);
                    pulse(1, h1, l1);
                    left1 -= h1 + l1;
                end
            end
            begin : drv_ctl
                repeat (8) begin
                    repeat ($urandom_range(80, 200)) @(negedge clk);
                    hi_thresh = CNT_W'($urandom_range(0, CMAX));
                    lo_thresh = CNT_W'($urandom_range(0, CMAX));
                    if ($urandom_range(0, 2) == 0) begin
                        enable = 1'b0;
                        l = $urandom_range(1, 40);
                        repeat (l) @(negedge clk);
                        enable = 1'b1;
                    end
                end
            end
        join
        repeat (3) @(negedge clk);
        check("dut0 expected queue drained", exp_q[0].size(), 0);
        check("dut1 expected queue drained", exp_q[1].size(), 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
